// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encodings and helpers for sequential arithmetic blocks
package serial_sub_pkg;

  // Common state encoding for the bit-serial arithmetic family
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: enough to count 0..w-1, never less than one bit
  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_sub_subbit.sv
// rtl/serial_sub_subbit.sv - one-bit full subtractor cell
module subbit (
  input  logic b,
  input  logic x,
  input  logic y,
  output logic d,
  output logic bnext
);

  // Difference and borrow-out of x - y - b
  always_comb begin
    d     = x ^ y ^ b;
    bnext = (~x & y) | (~(x ^ y) & b);
  end

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial n-bit subtractor, LSB first, one bit per clock
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         borrowin,
  input  logic [n-1:0] Xin,
  input  logic [n-1:0] Yin,
  output logic [n-1:0] D,
  output logic         borrowout,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(n);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [n-1:0]    x_q;       // minuend bits, refilled from the top with difference bits
  logic [n-1:0]    y_q;       // subtrahend bits, shifted right each RUN cycle
  logic            b_q;       // running borrow into the current bit
  logic [n-1:0]    d_q;
  logic            bo_q;
  logic            ov_q;

  logic            diff_bit;
  logic            borrow_next;
  logic            last_bit;

  subbit u_subbit (
    .b     (b_q),
    .x     (x_q[0]),
    .y     (y_q[0]),
    .d     (diff_bit),
    .bnext (borrow_next)
  );

  assign last_bit  = (cnt_q == CW'(n - 1));
  assign D         = d_q;
  assign borrowout = bo_q;
  assign overflow  = ov_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, serial datapath and result capture on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      b_q   <= 1'b0;
      cnt_q <= '0;
      d_q   <= '0;
      bo_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x_q   <= Xin;
            y_q   <= Yin;
            b_q   <= borrowin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          x_q   <= {diff_bit, x_q[n-1:1]};
          y_q   <= {1'b0, y_q[n-1:1]};
          b_q   <= borrow_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // b_q here is the borrow into the MSB, so XOR with its borrow-out gives signed overflow
            d_q  <= {diff_bit, x_q[n-1:1]};
            bo_q <= borrow_next;
            ov_q <= b_q ^ borrow_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
